// File: rtl/clock_time_counter_if.sv
// clock_time_counter_if: control pulses and time outputs of the timekeeping core.
interface clock_time_counter_if;
    logic       en;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic       clr_sec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick_1hz;
    logic       day_wrap;
    modport master (output en, set_mode, inc_min, inc_hour, clr_sec,
                    input sec, min, hour, tick_1hz, day_wrap);
    modport slave  (input en, set_mode, inc_min, inc_hour, clr_sec,
                    output sec, min, hour, tick_1hz, day_wrap);
endinterface

// File: rtl/clock_time_counter.sv
// clock_time_counter: 1 Hz prescaler plus 24-hour binary h/m/s with set mode.
module clock_time_counter #(
    parameter  int CLK_FREQ = 50_000_000,
    localparam int PS_W     = $clog2(CLK_FREQ)
) (
    input logic                  clk,
    input logic                  rst,
    clock_time_counter_if.slave  bus
);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ - 1);
    logic [PS_W-1:0] ps_q, ps_d;
    logic [5:0]      sec_q, sec_d, min_q, min_d;
    logic [4:0]      hour_q, hour_d;
    logic            tick_q, tick_d, wrap_q, wrap_d;
    logic            run, tick, sec_last, min_last, hour_last;
    assign run       = bus.en & ~bus.set_mode;
    assign tick      = run & (ps_q == PS_LAST);
    assign sec_last  = sec_q == 6'd59;
    assign min_last  = min_q == 6'd59;
    assign hour_last = hour_q == 5'd23;
    always_comb begin
        ps_d   = bus.set_mode ? '0 : tick ? '0 : run ? ps_q + 1'b1 : ps_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (bus.set_mode) begin
            if (bus.inc_min)  min_d  = min_last  ? 6'd0 : min_q + 6'd1;
            if (bus.inc_hour) hour_d = hour_last ? 5'd0 : hour_q + 5'd1;
            if (bus.clr_sec)  sec_d  = 6'd0;
        end else if (tick) begin
            sec_d = sec_last ? 6'd0 : sec_q + 6'd1;
            if (sec_last) min_d = min_last ? 6'd0 : min_q + 6'd1;
            if (sec_last && min_last) hour_d = hour_last ? 5'd0 : hour_q + 5'd1;
        end
        tick_d = tick;
        wrap_d = tick & sec_last & min_last & hour_last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q   <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end
    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.tick_1hz = tick_q;
    assign bus.day_wrap = wrap_q;
endmodule
